// File: rtl/sigma_delta_modulator.sv
// -----------------------------------------------------------------------------
// sigma_delta_modulator
//
// Second-order error-feedback sigma-delta modulator with a 9-level quantizer.
// It turns a signed PCM stream into codes in {-8,-6,...,+6,+8}, which drive
// the switching-tree x_in_i. The feedback is the previous code scaled by 4096,
// so a full-scale code of 8 matches a PCM value of 32768.
//
// Ports
//   clk_i        in   1            single clock, rising edge
//   reset_i      in   1            synchronous, active-high reset
//   din_i        in   INPUT_WIDTH  signed PCM sample
//   din_valid_i  in   1            din_i qualifier, one sample per cycle
//   clear_i      in   1            clears overload_o / ovl_cnt_o only
//   x_q_o        out  INPUT_WIDTH  signed quantized code
//   x_q_valid_o  out  1            one-cycle strobe per new x_q_o
//   overload_o   out  1            sticky overload flag
//   ovl_cnt_o    out  8            saturating overload event count
//
// Optional feature
//   SDM_DITHER_EN  when defined, a 16-bit LFSR adds +/-1 dither to the
//                  quantizer input. The stored integrator is not changed.
// -----------------------------------------------------------------------------
package lib_switchblock_pkg;
  localparam int SWB_DATA_WIDTH = 16;
endpackage

module sigma_delta_modulator
  import lib_switchblock_pkg::*;
#(
  parameter int INPUT_WIDTH = SWB_DATA_WIDTH,
  parameter int INT_WIDTH   = 24
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [INPUT_WIDTH-1:0] din_i,
  input  logic                   din_valid_i,
  input  logic                   clear_i,
  output logic [INPUT_WIDTH-1:0] x_q_o,
  output logic                   x_q_valid_o,
  output logic                   overload_o,
  output logic [7:0]             ovl_cnt_o
);

  // Two guard bits hold the sum of three INT_WIDTH-wide signed terms exactly.
  localparam int SW = INT_WIDTH + 2;

  localparam logic signed [INT_WIDTH-1:0] INT_MAX   = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] INT_MIN   = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0]        HALF_STEP = SW'(4096);
  localparam logic signed [SW-1:0]        LVL_MAX   = SW'(4);
  localparam logic signed [SW-1:0]        LVL_MIN   = SW'(-4);

  logic signed [INT_WIDTH-1:0] i1_q, i1_d;
  logic signed [INT_WIDTH-1:0] i2_q, i2_d;
  logic signed [4:0]           q_q, q_d;        // code in -8..+8
  logic                        x_q_valid_q, x_q_valid_d;
  logic                        overload_q, overload_d;
  logic [7:0]                  ovl_cnt_q, ovl_cnt_d;

  logic signed [17:0]          fb;
  logic signed [SW-1:0]        sum1, sum2, qin, lvl, lvl_c;
  logic signed [INT_WIDTH-1:0] i1n, i2n;
  logic                        ovf1, ovf2, lvl_ovf, ovl_event;

`ifdef SDM_DITHER_EN
  localparam logic signed [SW-1:0] DITHER_P = SW'(1);
  localparam logic signed [SW-1:0] DITHER_N = SW'(-1);
  logic [15:0] lfsr_q, lfsr_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; that is what keeps latches from being inferred.
    i1_d        = i1_q;
    i2_d        = i2_q;
    q_d         = q_q;
    x_q_valid_d = 1'b0;
    overload_d  = overload_q;
    ovl_cnt_d   = ovl_cnt_q;

    fb = {q_q[4], q_q, 12'd0};  // q_prev * 4096, sign-extended to 18 bits

    // A sum fits the integrator when its top three bits agree; otherwise
    // clamp toward its sign rather than wrap.
    sum1 = SW'(i1_q) + SW'($signed(din_i)) - SW'(fb);
    ovf1 = sum1[SW-1:INT_WIDTH-1] != {(SW-INT_WIDTH+1){sum1[SW-1]}};
    i1n  = ovf1 ? (sum1[SW-1] ? INT_MIN : INT_MAX) : sum1[INT_WIDTH-1:0];

    sum2 = SW'(i2_q) + SW'(i1n) - SW'(fb);
    ovf2 = sum2[SW-1:INT_WIDTH-1] != {(SW-INT_WIDTH+1){sum2[SW-1]}};
    i2n  = ovf2 ? (sum2[SW-1] ? INT_MIN : INT_MAX) : sum2[INT_WIDTH-1:0];

`ifdef SDM_DITHER_EN
    lfsr_d = lfsr_q;
    qin    = SW'(i2n) + (lfsr_q[0] ? DITHER_P : DITHER_N);
`else
    qin    = SW'(i2n);
`endif

    // Level = floor((qin + 4096) / 8192); the code is twice the level.
    lvl     = (qin + HALF_STEP) >>> 13;
    lvl_ovf = (lvl > LVL_MAX) || (lvl < LVL_MIN);
    lvl_c   = (lvl > LVL_MAX) ? LVL_MAX : ((lvl < LVL_MIN) ? LVL_MIN : lvl);

    ovl_event = din_valid_i && (ovf1 || ovf2 || lvl_ovf);

    if (din_valid_i) begin
      i1_d        = i1n;
      i2_d        = i2n;
      q_d         = {lvl_c[3:0], 1'b0};
      x_q_valid_d = 1'b1;
`ifdef SDM_DITHER_EN
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
    end

    // A clear in the same cycle as an event wins and the event is dropped.
    if (clear_i) begin
      overload_d = 1'b0;
      ovl_cnt_d  = 8'd0;
    end else if (ovl_event) begin
      overload_d = 1'b1;
      if (ovl_cnt_q != 8'hFF) ovl_cnt_d = ovl_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      i1_q        <= '0;
      i2_q        <= '0;
      q_q         <= '0;
      x_q_valid_q <= 1'b0;
      overload_q  <= 1'b0;
      ovl_cnt_q   <= 8'd0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      q_q         <= q_d;
      x_q_valid_q <= x_q_valid_d;
      overload_q  <= overload_d;
      ovl_cnt_q   <= ovl_cnt_d;
    end
  end

`ifdef SDM_DITHER_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`endif

  // x_q_o and q_prev always carry the same value, so one register serves both.
  assign x_q_o       = INPUT_WIDTH'(q_q);
  assign x_q_valid_o = x_q_valid_q;
  assign overload_o  = overload_q;
  assign ovl_cnt_o   = ovl_cnt_q;

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// -----------------------------------------------------------------------------
// tb_sigma_delta_modulator
//
// Self-checking bench for sigma_delta_modulator in the default build (no
// dither). A behavioural model in longint arithmetic predicts each code. The
// code is queued when the sample is driven and compared when x_q_valid_o
// rises. Overload flag and counter expectations come from the same model.
// -----------------------------------------------------------------------------
module tb_sigma_delta_modulator;

  localparam int IW = 16;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [IW-1:0] din_i = '0;
  logic          din_valid_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [IW-1:0] x_q_o;
  logic          x_q_valid_o;
  logic          overload_o;
  logic [7:0]    ovl_cnt_o;

  sigma_delta_modulator dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .din_i       (din_i),
    .din_valid_i (din_valid_i),
    .clear_i     (clear_i),
    .x_q_o       (x_q_o),
    .x_q_valid_o (x_q_valid_o),
    .overload_o  (overload_o),
    .ovl_cnt_o   (ovl_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  longint m_i1, m_i2, m_q;
  bit     m_ovl;
  int     m_cnt;
  bit     exp_valid;
  int     exp_q[$];

  localparam longint IMAX = (longint'(1) <<< 23) - 1;
  localparam longint IMIN = -(longint'(1) <<< 23);

  function automatic longint floor_div(input longint a, input longint b);
    longint r;
    r = a / b;
    if ((a % b != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  function automatic longint clamp_int(input longint v, output bit hit);
    hit = 1'b0;
    if (v > IMAX) begin hit = 1'b1; return IMAX; end
    if (v < IMIN) begin hit = 1'b1; return IMIN; end
    return v;
  endfunction

  // One modulator step from the current model state; no state is changed.
  function automatic void mdl_eval(input longint din, output longint i1n,
                                   output longint i2n, output longint q,
                                   output bit ev);
    longint fbv, qraw;
    bit s1, s2;
    fbv  = m_q * 4096;
    i1n  = clamp_int(m_i1 + din - fbv, s1);
    i2n  = clamp_int(m_i2 + i1n - fbv, s2);
    qraw = 2 * floor_div(i2n + 4096, 8192);
    q    = (qraw > 8) ? 8 : ((qraw < -8) ? -8 : qraw);
    ev   = s1 || s2 || (qraw > 8) || (qraw < -8);
  endfunction

  // Drive one cycle, advance the model, then score x_q_valid_o / x_q_o.
  task automatic step(input int din, input bit vld, input bit clr, input bit rst);
    longint i1n, i2n, q;
    bit ev;
    int expv, got;
    @(negedge clk_i);
    din_i       = IW'(din);
    din_valid_i = vld;
    clear_i     = clr;
    reset_i     = rst;
    if (rst) begin
      m_i1 = 0; m_i2 = 0; m_q = 0; m_ovl = 0; m_cnt = 0;
      exp_valid = 0;
      exp_q.delete();
    end else begin
      ev = 0;
      exp_valid = vld;
      if (vld) begin
        mdl_eval(longint'(din), i1n, i2n, q, ev);
        m_i1 = i1n; m_i2 = i2n; m_q = q;
        exp_q.push_back(int'(q));
      end
      if (clr) begin
        m_ovl = 0; m_cnt = 0;
      end else if (ev) begin
        m_ovl = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clk_i);
    #1;
    n_tests++;
    if (x_q_valid_o !== exp_valid) begin
      n_fail++;
      $display("FAIL x_q_valid_o: got %b expected %b", x_q_valid_o, exp_valid);
    end
    if (exp_valid && exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      if (x_q_valid_o === 1'b1) begin
        got = int'($signed(x_q_o));
        n_tests++;
        if (got !== expv) begin
          n_fail++;
          $display("FAIL x_q_o sample: got %0d expected %0d", got, expv);
        end
      end
    end
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_tests += 4;
    if (x_q_o !== '0) begin n_fail++; $display("FAIL reset x_q_o: got %0h expected 0", x_q_o); end
    if (x_q_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset x_q_valid_o: got %b expected 0", x_q_valid_o); end
    if (overload_o !== 1'b0) begin n_fail++; $display("FAIL reset overload_o: got %b expected 0", overload_o); end
    if (ovl_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset ovl_cnt_o: got %0d expected 0", ovl_cnt_o); end
  endtask

  task automatic test_dc_fixed_point();
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(16384, 1, 0, 0);
    n_tests += 2;
    if (int'($signed(x_q_o)) !== 4) begin n_fail++; $display("FAIL dc x_q_o: got %0d expected 4", $signed(x_q_o)); end
    if (overload_o !== 1'b0) begin n_fail++; $display("FAIL dc overload_o: got %b expected 0", overload_o); end
  endtask

  task automatic test_step_response();
    int sum;
    step(0, 0, 0, 1);
    for (int i = 0; i < 32; i++) step(8192, 1, 0, 0);
    n_tests++;
    if (int'($signed(x_q_o)) !== 2) begin n_fail++; $display("FAIL step plateau x_q_o: got %0d expected 2", $signed(x_q_o)); end
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      step(-32768, 1, 0, 0);
      if (i >= 16) sum += int'($signed(x_q_o));
    end
    n_tests++;
    if (sum !== -128) begin n_fail++; $display("FAIL step mean (sum of 16): got %0d expected -128", sum); end
  endtask

  task automatic test_valid_gaps();
    step(0, 0, 0, 1);
    step(8192, 1, 0, 0);
    step(8192, 0, 0, 0);
    n_tests++;
    if (int'($signed(x_q_o)) !== 2) begin n_fail++; $display("FAIL gap hold 1 x_q_o: got %0d expected 2", $signed(x_q_o)); end
    step(8192, 0, 0, 0);
    n_tests++;
    if (int'($signed(x_q_o)) !== 2) begin n_fail++; $display("FAIL gap hold 2 x_q_o: got %0d expected 2", $signed(x_q_o)); end
    step(8192, 1, 0, 0);
  endtask

  task automatic test_mid_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(32767, 1, 0, 0);
    step(32767, 1, 0, 1);  // sample offered during reset is discarded
    step(32767, 1, 0, 0);
    n_tests += 2;
    if (int'($signed(x_q_o)) !== 8) begin n_fail++; $display("FAIL mid-reset x_q_o: got %0d expected 8", $signed(x_q_o)); end
    if (int'($signed(dut.i1_q)) !== 32767) begin n_fail++; $display("FAIL mid-reset i1: got %0d expected 32767", $signed(dut.i1_q)); end
  endtask

  task automatic test_overload_clear();
    longint i1n, i2n, q;
    bit ev, done, seen;
    int din;
    step(0, 0, 0, 1);
    done = 0;
    seen = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      din = (k % 2 == 0) ? 32767 : -32768;
      mdl_eval(longint'(din), i1n, i2n, q, ev);
      if (m_ovl && ev) begin
        step(din, 1, 1, 0);  // clear coincides with an overload event
        done = 1;
      end else begin
        step(din, 1, 0, 0);
        if (m_ovl && !seen) begin
          seen = 1;
          n_tests += 2;
          if (overload_o !== 1'b1) begin n_fail++; $display("FAIL overload set: got %b expected 1", overload_o); end
          if (ovl_cnt_o !== 8'(m_cnt)) begin n_fail++; $display("FAIL overload count: got %0d expected %0d", ovl_cnt_o, m_cnt); end
        end
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL overload timeout: got no coincident event in 1000 samples, expected one");
    end else begin
      n_tests++;
      if (overload_o !== 1'b0) begin n_fail++; $display("FAIL clear overload_o: got %b expected 0", overload_o); end
      if (ovl_cnt_o !== 8'd0) begin n_fail++; $display("FAIL clear ovl_cnt_o: got %0d expected 0", ovl_cnt_o); end
    end
  endtask

  task automatic test_count_saturate();
    // Keep overdriving; the model decides how many events occur.
    for (int k = 0; k < 1500; k++) step((k % 2 == 0) ? 32767 : -32768, 1, 0, 0);
    n_tests += 2;
    if (ovl_cnt_o !== 8'(m_cnt)) begin n_fail++; $display("FAIL count after overdrive: got %0d expected %0d", ovl_cnt_o, m_cnt); end
    if (overload_o !== m_ovl) begin n_fail++; $display("FAIL overload after overdrive: got %b expected %b", overload_o, m_ovl); end
    step(0, 0, 1, 0);  // clear alone
    n_tests++;
    if (ovl_cnt_o !== 8'd0) begin n_fail++; $display("FAIL clear alone ovl_cnt_o: got %0d expected 0", ovl_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_dc_fixed_point();
    test_step_response();
    test_valid_gaps();
    test_mid_reset();
    test_overload_clear();
    test_count_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigma_delta_modulator.md
SIGMA_DELTA_MODULATOR -- requirements
Module: sigma_delta_modulator

Interface
REQ-001 Parameter INPUT_WIDTH, default from lib_switchblock_pkg (16): width of din_i and x_q_o.
REQ-002 Parameter INT_WIDTH, default 24: integrator register width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 din_i  input  INPUT_WIDTH  signed PCM sample.
REQ-006 din_valid_i  input  1  din_i qualifier; one sample accepted per cycle when high.
REQ-007 clear_i  input  1  clears overload_o and ovl_cnt_o only.
REQ-008 x_q_o  output  INPUT_WIDTH  signed quantized code in {-8,-6,-4,-2,0,2,4,6,8}; drives switching-tree x_in_i.
REQ-009 x_q_valid_o  output  1  high one cycle per new x_q_o.
REQ-010 overload_o  output  1  sticky overload indicator.
REQ-011 ovl_cnt_o  output  8  saturating count of overload events.

Function
REQ-012 Topology: second-order error-feedback modulator, 9-level quantizer, fb = q_prev * 4096, fb held 18-bit signed.
REQ-013 On accepted sample: i1n = sat(i1 + din_i - fb); i2n = sat(i2 + i1n - fb); sat clamps to INT_WIDTH signed range.
REQ-014 Quantizer: q_raw = 2*floor((i2n + 4096)/8192); q = clamp(q_raw, -8, +8).
REQ-015 i1, i2, q_prev register i1n, i2n, q on the cycle after the accepted sample; x_q_o = q and x_q_valid_o = 1 on that same edge (latency 1 cycle).
REQ-016 din_valid_i low: integrators, q_prev, x_q_o hold; x_q_valid_o = 0.
REQ-017 Overload event: q_raw outside [-8,+8] or either integrator saturates on an accepted sample.
REQ-018 Overload event sets overload_o next edge; ovl_cnt_o increments, saturating at 255.
REQ-019 clear_i high: overload_o = 0, ovl_cnt_o = 0 next edge; clear_i and overload event in same cycle: clear wins, event not counted.
REQ-020 clear_i has no effect on integrators, q_prev, x_q_o.
REQ-021 Arithmetic sign-extended before add; no wrap-around in any integrator.
REQ-022 Fixed points: constant din_i = k*4096 (k even, |k| <= 8) from reset yields x_q_o = k on every sample.

Reset
REQ-023 reset_i high at an edge: i1, i2, q_prev, x_q_o = 0; x_q_valid_o = 0; overload_o = 0; ovl_cnt_o = 0; dither LFSR = 16'hACE1.
REQ-024 reset_i overrides din_valid_i and clear_i in the same cycle; sample presented during reset discarded.
REQ-025 First sample accepted after reset_i deasserts processes from zero state.

Configuration
REQ-026 Macro SDM_DITHER_EN defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances on each accepted sample; bit0 = 1 adds +1, bit0 = 0 adds -1 to i2n before quantizer only (not to stored i2).
REQ-027 SDM_DITHER_EN undefined: no LFSR logic; quantizer input is i2n exactly.

Verification
REQ-028 reset_i high 2 cycles, din_valid_i = 0 -> all outputs 0, x_q_valid_o = 0.
REQ-029 din_i = 16384, din_valid_i = 1 continuous from reset (dither off) -> x_q_o = 4 every sample, x_q_valid_o 1 cycle after each input, overload_o = 0.
REQ-030 din_i = 8192 then -32768, 32 samples each (dither off) -> x_q_o = 2 steady, then settles to -8, mean over last 16 samples = -8.
REQ-031 din_valid_i toggled 1,0,0,1 with din_i = 8192 -> x_q_valid_o pulses only after valid cycles; x_q_o holds 2 across gap.
REQ-032 din_i = 32767 continuous, mid-run reset_i 1 cycle -> next output after reset recomputed from zero state (x_q_o = 8, i1 = 32767).
REQ-033 Alternating din_i 32767/-32768 each sample until overload_o = 1, then clear_i with coincident overload -> overload_o = 0, ovl_cnt_o = 0 next cycle.
